// File: rtl/bit_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// bit_serial_adder_pkg
// Shared types and limits for the bit-serial adder.
//   bsa_state_t   : controller states (IDLE -> RUN -> DONE -> IDLE)
//   BSA_MAX_WIDTH : largest supported operand width
// Optional feature macro used by the top level: BSA_OVF_EN (adds the ovf port).
// -----------------------------------------------------------------------------
package bit_serial_adder_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } bsa_state_t;

   localparam int BSA_MAX_WIDTH = 64;

endpackage : bit_serial_adder_pkg

// File: rtl/bit_serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Single-bit full adder cell used as the arithmetic core of the serial adder.
// Ports:
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
// -----------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule : full_adder

// File: rtl/bit_serial_adder.sv
// -----------------------------------------------------------------------------
// bit_serial_adder
// LSB-first sequential adder: one full_adder cell plus a carry flop computes
// {cout,sum} = a + b + cin over WIDTH clocks, then holds the result.
// Parameters:
//   WIDTH  operand/sum width, 2..BSA_MAX_WIDTH
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : request, sampled only while ready=1
//   a, b, cin  : operands and carry-in, captured on an accepted start
//   ready      : controller idle, start accepted this cycle
//   busy       : bit-serial addition in progress
//   done       : one-cycle pulse when sum/cout(/ovf) have just been updated
//   sum, cout  : registered result, held until the next completed operation
//   ovf        : signed overflow, held like sum (only when BSA_OVF_EN is defined)
// Optional feature macro: BSA_OVF_EN.
// -----------------------------------------------------------------------------
module bit_serial_adder
   import bit_serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef BSA_OVF_EN
   output logic             cout,
   output logic             ovf
`else
   output logic             cout
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   if (WIDTH < 2 || WIDTH > BSA_MAX_WIDTH) begin : g_width_check
      $error("bit_serial_adder: WIDTH=%0d outside legal range 2..%0d", WIDTH, BSA_MAX_WIDTH);
   end

   bsa_state_t       state;
   bsa_state_t       state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-2:0] s_sr;   // sum bits produced so far; the newest bit joins on top
   logic [WIDTH-1:0] s_cat;
   logic             c_ff;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_co;

   full_adder u_fa (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .ci (c_ff),
      .s  (fa_s),
      .co (fa_co)
   );

   // On the final RUN cycle this is the complete sum: newest bit in the MSB.
   assign s_cat = {fa_s, s_sr};

   // NOTE: every output of this block gets a default first so no path leaves
   // a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            ready = 1'b1;
            if (start) state_nxt = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (cnt == CNT_LAST) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values of its neighbours, exactly like the hardware.
   // NOTE: the datapath registers are reset too, so an abandoned operation
   // leaves no stale operand or carry behind and the held result reads zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         a_sr  <= '0;
         b_sr  <= '0;
         s_sr  <= '0;
         c_ff  <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef BSA_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_sr <= a;
                  b_sr <= b;
                  c_ff <= cin;
                  cnt  <= '0;
               end
            end
            S_RUN: begin
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               s_sr <= s_cat[WIDTH-1:1];
               c_ff <= fa_co;
               cnt  <= cnt + CW'(1);
               if (cnt == CNT_LAST) begin
                  sum  <= s_cat;
                  cout <= fa_co;
`ifdef BSA_OVF_EN
                  // Carry into the MSB differs from carry out of it: signed overflow.
                  ovf  <= c_ff ^ fa_co;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule : bit_serial_adder

// File: tb/tb_bit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_adder
// Self-checking bench for bit_serial_adder: directed corner cases plus random
// operations compared against plain integer arithmetic. A second instance with
// WIDTH=2 covers the narrowest legal configuration.
// Optional feature macro: BSA_OVF_EN (checks the ovf port when defined).
// -----------------------------------------------------------------------------
module tb_bit_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;

   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   logic         start2;
   logic [1:0]   a2;
   logic [1:0]   b2;
   logic         cin2;
   logic         ready2;
   logic         busy2;
   logic         done2;
   logic [1:0]   sum2;
   logic         cout2;

`ifdef BSA_OVF_EN
   logic         ovf;
   logic         ovf2;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bit_serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
`ifdef BSA_OVF_EN
      .cout  (cout),
      .ovf   (ovf)
`else
      .cout  (cout)
`endif
   );

   bit_serial_adder #(.WIDTH(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start2),
      .a     (a2),
      .b     (b2),
      .cin   (cin2),
      .ready (ready2),
      .busy  (busy2),
      .done  (done2),
      .sum   (sum2),
`ifdef BSA_OVF_EN
      .cout  (cout2),
      .ovf   (ovf2)
`else
      .cout  (cout2)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // All tasks run in the phase 1 time unit after a rising edge.
   task automatic wait_ready(input string tag);
      int n = 0;
      while (!ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ready) check({tag, "_ready_timeout"}, ready, 1);
   endtask

   // mode 0: quiet inputs; 1: random input churn during RUN;
   // 2: a start pulse with different operands in the middle of RUN.
   task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input int mode);
      logic [W:0]   exp_full;
      logic [W-1:0] old_sum;
      logic         old_cout;
      logic         held_ok;
      int           cyc;
`ifdef BSA_OVF_EN
      logic         exp_ovf;
      logic         old_ovf;
`endif
      exp_full = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
`ifdef BSA_OVF_EN
      // Signed overflow: operands share a sign the truncated result lacks.
      exp_ovf = (ta[W-1] == tb_v[W-1]) && (exp_full[W-1] != ta[W-1]);
`endif
      wait_ready(tag);
      old_sum  = sum;
      old_cout = cout;
`ifdef BSA_OVF_EN
      old_ovf  = ovf;
`endif
      held_ok  = 1'b1;
      a = ta; b = tb_v; cin = tc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc   = 1;
      while (!done && cyc < W + 8) begin
         if (sum !== old_sum || cout !== old_cout) held_ok = 1'b0;
`ifdef BSA_OVF_EN
         if (ovf !== old_ovf) held_ok = 1'b0;
`endif
         if (mode == 1) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); start = 1'($urandom);
         end
         if (mode == 2 && cyc == 3) begin
            a = W'(8'h10); b = W'(8'h20); cin = 1'b0; start = 1'b1;
         end
         if (mode == 2 && cyc == 4) start = 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      check({tag, "_done"}, done, 1);
      check({tag, "_latency"}, cyc, W + 1);
      check({tag, "_sum"}, sum, exp_full[W-1:0]);
      check({tag, "_cout"}, cout, exp_full[W]);
      check({tag, "_held"}, held_ok, 1);
`ifdef BSA_OVF_EN
      check({tag, "_ovf"}, ovf, exp_ovf);
`endif
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, done, 0);
   endtask

   task automatic run_op2(input logic [1:0] ta, input logic [1:0] tb_v, input logic tc);
      logic [2:0] exp_full;
      int         n;
      exp_full = {1'b0, ta} + {1'b0, tb_v} + {2'b00, tc};
      n = 0;
      while (!ready2 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      a2 = ta; b2 = tb_v; cin2 = tc; start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      n = 1;
      while (!done2 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      check("w2_done", done2, 1);
      check("w2_latency", n, 3);
      check("w2_sum", sum2, exp_full[1:0]);
      check("w2_cout", cout2, exp_full[2]);
   endtask

   initial begin
      int done_cyc[$];
      int ready_cnt;
      bit seen_done;

      rst_n = 1'b0;
      start = 1'b0; a = '0; b = '0; cin = 1'b0;
      start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
      #12;
      check("rst_ready", ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_ready2", ready2, 1);
`ifdef BSA_OVF_EN
      check("rst_ovf", ovf, 0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases.
      run_op("t1_5p3", 8'h05, 8'h03, 1'b0, 0);
      run_op("t2_ffp1", 8'hFF, 8'h01, 1'b0, 0);
      run_op("t2_7fp1", 8'h7F, 8'h01, 1'b0, 0);
      run_op("t3_ffpff", 8'hFF, 8'hFF, 1'b1, 0);
      run_op("t4_ignore", 8'h01, 8'h01, 1'b0, 2);
      run_op("t_neg_ovf", 8'h80, 8'h80, 1'b0, 0);
      run_op("t_cin_ovf", 8'h7F, 8'h00, 1'b1, 0);

      // Narrowest width: the specific corner, then every input combination.
      run_op2(2'b11, 2'b11, 1'b1);
      for (int i = 0; i < 32; i++) run_op2(i[1:0], i[3:2], i[4]);

      // Start held high: back-to-back operations.
      wait_ready("t5");
      ready_cnt = 0;
      a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
      for (int i = 0; i < 35; i++) begin
         @(posedge clk); #1;
         if (done) begin
            done_cyc.push_back(i);
            check("t5_sum", sum, 8'h33);
         end
         if (ready && done_cyc.size() == 1) ready_cnt++;
         if (ready && busy) check("t5_ready_busy", 1, 0);
      end
      start = 1'b0;
      check("t5_done_count", done_cyc.size(), 3);
      if (done_cyc.size() >= 3) begin
         check("t5_period1", done_cyc[1] - done_cyc[0], 10);
         check("t5_period2", done_cyc[2] - done_cyc[1], 10);
      end
      check("t5_ready_per_op", ready_cnt, 1);

      // Reset in the middle of RUN.
      wait_ready("t6");
      a = 8'h5A; b = 8'h3C; cin = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("t6_busy_before", busy, 1);
      check("t6_sum_before", sum, 8'h33);
      #2 rst_n = 1'b0;
      #1;
      check("t6_ready", ready, 1);
      check("t6_busy", busy, 0);
      check("t6_done", done, 0);
      check("t6_sum", sum, 0);
      check("t6_cout", cout, 0);
`ifdef BSA_OVF_EN
      check("t6_ovf", ovf, 0);
`endif
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("t6_ready_after", ready, 1);
      seen_done = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (done) seen_done = 1'b1;
      end
      check("t6_no_done", seen_done, 0);

      // Random operations, half of them with input churn while running.
      for (int i = 0; i < 1000; i++) begin
         run_op("rnd", W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_bit_serial_adder
